// File: rtl/ram_sync_storage.sv
// ram_sync_storage: single-port synchronous data RAM with registered read data,
// a 1- or 2-cycle read pipeline, a read-valid strobe, and a clear engine that
// zeroes the whole array after reset or on request while holding busy high.
module ram_sync_storage #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  busy
);

   localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   ptr;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    idle;
   logic                    take;
   logic                    wr_en;
   logic                    rd_en;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   logic                    rd_v0;
   logic [DATA_WIDTH-1:0]   rd_data0;
   logic                    last_v;
   logic [DATA_WIDTH-1:0]   last_data;

   // An access is only taken in IDLE, and a same-cycle clear request wins over it.
   assign idle      = (state == ST_IDLE);
   assign take      = idle & cs & ~clear;
   assign wr_en     = take & ~rw;
   assign rd_en     = take & rw;

   // The sweep owns the write port whenever it runs.
   assign mem_we    = wr_en | (state == ST_CLEAR);
   assign mem_waddr = (state == ST_CLEAR) ? ptr : addr;
   assign mem_wdata = (state == ST_CLEAR) ? '0 : data_in;

   // Clear engine: IDLE waits for a clear request, CLEAR walks every word once.
   // NOTE: every register in a clocked block uses <= so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         ptr   <= '0;
         busy  <= (CLEAR_ON_RESET != 0);
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear) begin
                  state <= ST_CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               ptr <= ptr + ADDR_WIDTH'(1);
               if (ptr == PTR_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Storage array plus its read register; read-first, so a read sees the
   // contents as they were before any write at the same edge.
   // NOTE: the array is deliberately left out of reset so it maps onto block RAM; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (rd_en) begin
         rd_data0 <= mem[addr];
      end
   end

   // First read stage valid bit; flushed by reset so no stale strobe escapes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v0 <= 1'b0;
      end else begin
         rd_v0 <= rd_en;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  rd_v1;
         logic [DATA_WIDTH-1:0] rd_data1;

         // Extra fully pipelined stage between the array read and the output register.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_v1    <= 1'b0;
               rd_data1 <= '0;
            end else begin
               rd_v1 <= rd_v0;
               if (rd_v0) begin
                  rd_data1 <= rd_data0;
               end
            end
         end

         assign last_v    = rd_v1;
         assign last_data = rd_data1;
      end else begin : g_lat1
         assign last_v    = rd_v0;
         assign last_data = rd_data0;
      end
   endgenerate

   // Output register: loads only on a completing read, otherwise holds the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= last_v;
         if (last_v) begin
            data_out <= last_data;
         end
      end
   end

endmodule

// File: tb/tb_ram_sync_storage.sv
// Directed bench for ram_sync_storage: three instances (latency 1 with clear on
// reset, latency 2 / 16-bit with clear on reset, latency 1 without clear on
// reset) share clock and bus inputs; each has its own reset.
module tb_ram_sync_storage;

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   logic        rst_c;
   logic        cs;
   logic        rw;
   logic [7:0]  addr;
   logic [15:0] data_in;
   logic        clear;

   logic [7:0]  data_out_a;
   logic        rd_valid_a;
   logic        busy_a;
   logic [15:0] data_out_b;
   logic        rd_valid_b;
   logic        busy_b;
   logic [7:0]  data_out_c;
   logic        rd_valid_c;
   logic        busy_c;

   int n_checks = 0;
   int n_fail   = 0;

   ram_sync_storage #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_a), .cs(cs), .rw(rw), .addr(addr),
      .data_in(data_in[7:0]), .clear(clear),
      .data_out(data_out_a), .rd_valid(rd_valid_a), .busy(busy_a)
   );

   ram_sync_storage #(
      .DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_b), .cs(cs), .rw(rw), .addr(addr),
      .data_in(data_in), .clear(clear),
      .data_out(data_out_b), .rd_valid(rd_valid_b), .busy(busy_b)
   );

   ram_sync_storage #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
   ) dut_c (
      .clk(clk), .rst_n(rst_c), .cs(cs), .rw(rw), .addr(addr),
      .data_in(data_in[7:0]), .clear(clear),
      .data_out(data_out_c), .rd_valid(rd_valid_c), .busy(busy_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] a, input logic [15:0] d);
      cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
      tick();
      cs = 1'b0;
   endtask

   // Single latency-1 read on instance a (which=0) or c (which=1).
   task automatic read_chk(input int which, input logic [7:0] a, input logic [7:0] exp,
                           input string tag);
      cs = 1'b1; rw = 1'b1; addr = a;
      tick();
      cs = 1'b0;
      tick();
      if (which == 0) begin
         check({tag, "_valid"}, {31'd0, rd_valid_a}, 32'd1);
         check({tag, "_data"}, {24'd0, data_out_a}, {24'd0, exp});
      end else begin
         check({tag, "_valid"}, {31'd0, rd_valid_c}, 32'd1);
         check({tag, "_data"}, {24'd0, data_out_c}, {24'd0, exp});
      end
   endtask

   // Count sampled cycles with busy high on instance a or b, bounded.
   task automatic count_busy(input int which, output int n);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (((which == 0) ? busy_a : busy_b) == 1'b0) break;
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int pulses;

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      cs = 1'b0; rw = 1'b0; addr = '0; data_in = '0; clear = 1'b0;

      // Reset state
      #12;
      check("rst_a_data", {24'd0, data_out_a}, 32'd0);
      check("rst_a_valid", {31'd0, rd_valid_a}, 32'd0);
      check("rst_a_busy", {31'd0, busy_a}, 32'd1);
      check("rst_c_busy", {31'd0, busy_c}, 32'd0);

      @(posedge clk);
      #1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      check("c_busy_after_rel", {31'd0, busy_c}, 32'd0);
      count_busy(0, n);
      check("a_init_sweep_len", n, 32'd256);
      check("b_idle_after_sweep", {31'd0, busy_b}, 32'd0);

      // Post-clear contents at low, middle and top addresses
      read_chk(0, 8'h00, 8'h00, "clr_rd00");
      read_chk(0, 8'h7F, 8'h00, "clr_rd7f");
      read_chk(0, 8'hFF, 8'h00, "clr_rdff");

      // Write then read on the next cycle; data holds after cs drops
      cs = 1'b1; rw = 1'b0; addr = 8'h10; data_in = 16'h00A5;
      tick();
      rw = 1'b1;
      tick();
      cs = 1'b0;
      check("raw_no_early_valid", {31'd0, rd_valid_a}, 32'd0);
      tick();
      check("raw_valid", {31'd0, rd_valid_a}, 32'd1);
      check("raw_data", {24'd0, data_out_a}, 32'h0000_00A5);
      tick();
      check("raw_valid_drop", {31'd0, rd_valid_a}, 32'd0);
      check("raw_data_hold", {24'd0, data_out_a}, 32'h0000_00A5);

      // Latency 2, 16-bit: back-to-back reads return in order
      write_word(8'h03, 16'h1234);
      write_word(8'h04, 16'hBEEF);
      cs = 1'b1; rw = 1'b1; addr = 8'h03;
      tick();
      addr = 8'h04;
      tick();
      cs = 1'b0;
      check("l2_no_early_valid", {31'd0, rd_valid_b}, 32'd0);
      tick();
      check("l2_first_valid", {31'd0, rd_valid_b}, 32'd1);
      check("l2_first_data", {16'd0, data_out_b}, 32'h0000_1234);
      tick();
      check("l2_second_valid", {31'd0, rd_valid_b}, 32'd1);
      check("l2_second_data", {16'd0, data_out_b}, 32'h0000_BEEF);
      tick();
      check("l2_valid_drop", {31'd0, rd_valid_b}, 32'd0);
      check("l2_data_hold", {16'd0, data_out_b}, 32'h0000_BEEF);

      // clear beats a same-cycle write; bus activity during the sweep is ignored
      clear = 1'b1; cs = 1'b1; rw = 1'b0; addr = 8'h20; data_in = 16'h0055;
      tick();
      clear = 1'b0;
      check("clr_busy_rise", {31'd0, busy_a}, 32'd1);
      n = 0;
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!busy_a) break;
         n++;
         cs = 1'b1; rw = i[0]; addr = 8'h05; data_in = 16'h0099;
         clear = (i == 50);
         tick();
         if (rd_valid_a) pulses++;
      end
      cs = 1'b0; clear = 1'b0;
      check("clr_sweep_len", n, 32'd256);
      check("clr_no_rd_valid", pulses, 32'd0);
      read_chk(0, 8'h20, 8'h00, "clr_dropped_wr");
      read_chk(0, 8'h05, 8'h00, "clr_ignored_wr");

      // Asynchronous reset in the middle of a sweep
      write_word(8'h40, 16'h003C);
      read_chk(0, 8'h40, 8'h3C, "pre_rst_rd");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (100) tick();
      #2;
      rst_a = 1'b0;
      #1;
      check("midrst_data", {24'd0, data_out_a}, 32'd0);
      check("midrst_valid", {31'd0, rd_valid_a}, 32'd0);
      check("midrst_busy", {31'd0, busy_a}, 32'd1);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      count_busy(0, n);
      check("midrst_sweep_len", n, 32'd256);

      // No clear on reset: top address is distinct from address 0
      check("c_idle", {31'd0, busy_c}, 32'd0);
      write_word(8'h00, 16'h0011);
      write_word(8'hFF, 16'h00FF);
      read_chk(1, 8'h00, 8'h11, "c_rd00");
      read_chk(1, 8'hFF, 8'hFF, "c_rdff");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_sync_storage.md
Name: ram_sync_storage

Overview:
- Clocked, parametrised successor to the team's combinational 8-bit RAM store.
- Single-port memory with registered read data and configurable read latency (1 or 2 cycles).
- A read-valid strobe marks returned data; a built-in clear engine zeroes the array after reset or on request.
- Sits on the processor data bus as general-purpose data RAM; the busy flag lets the controller stall during clear.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the data ports
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words (derived, not overridable)
READ_LATENCY, 1, cycles from read accept to data_out/rd_valid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = run clear sweep automatically after rst_n deasserts; 0 = start in IDLE, contents undefined

Ports:
clk       input   1           rising-edge clock
rst_n     input   1           asynchronous active-low reset
cs        input   1           chip select, active high; access taken at clk edge when cs=1 and busy=0
rw        input   1           1 = read, 0 = write
addr      input   ADDR_WIDTH  word address
data_in   input   DATA_WIDTH  write data
clear     input   1           single-cycle request to zero the whole array; sampled in IDLE only
data_out  output  DATA_WIDTH  registered read data; holds last read value between reads
rd_valid  output  1           one-cycle pulse when data_out carries new read data
busy      output  1           1 while clear sweep runs; accesses ignored

Behaviour:
- Reset (rst_n=0, async): data_out=0, rd_valid=0, read pipeline flushed.
  - State goes to CLEAR with sweep pointer=0 if CLEAR_ON_RESET=1, else IDLE; busy=1 in CLEAR.
  - rst_n does not touch array contents directly.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR: clear=1 at a clk edge; pointer loads 0; busy rises the next cycle.
  - CLEAR: each cycle writes 0 to memory[pointer], pointer+1; at pointer=DEPTH-1 writes last word and returns to IDLE.
  - Sweep takes exactly DEPTH cycles; busy=0 from the first IDLE cycle.
- Priority at an IDLE edge: clear beats cs. If clear=1 and cs=1 in the same cycle, the access is dropped and the sweep starts.
- In CLEAR, cs/rw/addr/data_in/clear are ignored; no rd_valid is generated for dropped reads.
- Write (IDLE, cs=1, rw=0): memory[addr] <= data_in at the edge; no rd_valid; data_out unchanged.
- Read (IDLE, cs=1, rw=1): request captured at edge E.
  - READ_LATENCY=1: data_out=memory[addr] and rd_valid=1 after edge E+1.
  - READ_LATENCY=2: the same after edge E+2; the extra output register stage is fully pipelined.
  - Back-to-back reads are accepted every cycle, producing one rd_valid per read in order.
- Read-after-write to the same address on the next cycle returns the newly written data.
- Reads already in the pipeline when clear is accepted complete normally with pre-clear data.
- cs=0: no access; data_out holds its value; rd_valid=0 unless a pipelined read is completing.
- Address uses all ADDR_WIDTH bits, with no aliasing or wrap beyond DEPTH-1. Pointer wrap at DEPTH-1 ends the sweep; it does not restart it.
- rst_n asserted mid-sweep or mid-read: pipeline flushed, rd_valid=0. With CLEAR_ON_RESET=1 the sweep restarts from pointer 0; with 0 the block enters IDLE and partially cleared contents are undefined.
- clear asserted while busy=1 has no effect; it is not queued.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, DEPTH=256: busy=1 for exactly 256 cycles, then 0. Reads of addr 0x00, 0x7F, 0xFF return 0x00 with rd_valid.
- Write 0xA5 to 0x10, then read 0x10 on the next cycle (READ_LATENCY=1): data_out=0xA5 and rd_valid=1 one edge after the read. data_out holds 0xA5 after cs drops.
- READ_LATENCY=2, DATA_WIDTH=16: write 0x1234@3 and 0xBEEF@4, then read 3 and 4 back-to-back. Two consecutive rd_valid pulses arrive two cycles after each request, in order 0x1234, 0xBEEF.
- clear and cs-write 0x55@0x20 asserted in the same IDLE cycle: write dropped, busy rises. After the sweep, reading 0x20 returns 0x00. cs activity during the sweep produces no rd_valid and no writes.
- Reset mid-sweep at pointer 100: data_out=0 and rd_valid=0 immediately, without waiting for clk. After release, busy lasts a full 256 cycles.
- CLEAR_ON_RESET=0: busy=0 right after reset. Write/read of 0xFF at 0xFF is returned correctly, confirming the top address has no wrap.
